// File: rtl/rpn_core_param.sv
// rpn_core_param: parametrised RPN engine with a registered operand stack,
// sticky error code and a one-cycle deferred-op handshake (busy).
// Optional feature macro: RPN_DIVIDE_EN enables signed DIV/MOD (opcodes 3/4);
// when undefined, those opcodes report INVALID and no divider is built.
module rpn_core_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             num_en,
  input  logic [WIDTH-1:0] num,
  input  logic             op_en,
  input  logic [3:0]       op,
  output logic             busy,
  output logic [WIDTH-1:0] res_value,
  output logic             res_ready,
  output logic [2:0]       err,
  output logic [DW-1:0]    depth
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, DEFER} state_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0, ERR_UNDER = 3'd1, ERR_OVER = 3'd2,
    ERR_DIVZ = 3'd3, ERR_INVALID = 3'd4
  } err_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
    OP_MOD = 4'd4, OP_NEG = 4'd5, OP_DUP = 4'd6, OP_SWAP = 4'd7,
    OP_DROP = 4'd8, OP_PRINT = 4'd9, OP_CLEAR = 4'd10
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  state_e           state_q, state_n;
  err_e             err_q, err_n;
  logic [DW-1:0]    depth_q, depth_n, dm1, dm2;
  logic [3:0]       op_q, act_code;
  logic             drop_q;
  logic             act_push, act_op, latch, push_ovf, prn;
  logic [WIDTH-1:0] top, sec, alu_res;
  logic             wa_en, wb_en;
  logic [AW-1:0]    wa_addr, wb_addr;
  logic [WIDTH-1:0] wa_data, wb_data;

  assign dm1       = depth_q - DW'(1);
  assign dm2       = depth_q - DW'(2);
  assign top       = mem[dm1[AW-1:0]];
  assign sec       = mem[dm2[AW-1:0]];
  assign busy      = (state_q == DEFER);
  assign err       = err_q;
  assign depth     = depth_q;

  // Sequencing: pick at most one action (push or op) for this cycle.
  always_comb begin
    state_n  = state_q;
    act_push = 1'b0;
    act_op   = 1'b0;
    act_code = op;
    latch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (num_en && op_en) begin
          act_push = 1'b1;
          latch    = 1'b1;
          state_n  = DEFER;
        end else if (num_en) begin
          act_push = 1'b1;
        end else if (op_en) begin
          act_op = 1'b1;
        end
      end
      DEFER: begin
        act_op   = !drop_q;
        act_code = op_q;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Arithmetic on a (second) and b (top); wraps modulo 2^WIDTH.
  always_comb begin
    alu_res = '0;
    case (act_code)
      OP_ADD: alu_res = sec + top;
      OP_SUB: alu_res = sec - top;
      OP_MUL: alu_res = sec * top;
`ifdef RPN_DIVIDE_EN
      OP_DIV: alu_res = $signed(sec) / $signed(top);
      OP_MOD: alu_res = $signed(sec) % $signed(top);
`endif
      default: alu_res = '0;
    endcase
  end

  // Execute the selected action: error checks, stack writes, depth update.
  always_comb begin
    depth_n  = depth_q;
    err_n    = err_q;
    push_ovf = 1'b0;
    prn      = 1'b0;
    wa_en    = 1'b0;
    wa_addr  = depth_q[AW-1:0];
    wa_data  = num;
    wb_en    = 1'b0;
    wb_addr  = dm2[AW-1:0];
    wb_data  = alu_res;
    if (act_push && err_q == ERR_NONE) begin
      if (depth_q == DW'(DEPTH)) begin
        err_n    = ERR_OVER;
        push_ovf = 1'b1;
      end else begin
        wa_en   = 1'b1;
        depth_n = depth_q + DW'(1);
      end
    end
    if (act_op) begin
      if (act_code == OP_CLEAR) begin
        depth_n = '0;
        err_n   = ERR_NONE;
      end else if (err_q == ERR_NONE) begin
        case (act_code)
          OP_ADD, OP_SUB, OP_MUL: begin
            if (depth_q < DW'(2)) err_n = ERR_UNDER;
            else begin
              wb_en   = 1'b1;
              depth_n = dm1;
            end
          end
`ifdef RPN_DIVIDE_EN
          OP_DIV, OP_MOD: begin
            if (depth_q < DW'(2)) err_n = ERR_UNDER;
            else if (top == '0) err_n = ERR_DIVZ;
            else begin
              wb_en   = 1'b1;
              depth_n = dm1;
            end
          end
`endif
          OP_NEG: begin
            if (depth_q == '0) err_n = ERR_UNDER;
            else begin
              wa_en   = 1'b1;
              wa_addr = dm1[AW-1:0];
              wa_data = -top;
            end
          end
          OP_DUP: begin
            if (depth_q == '0) err_n = ERR_UNDER;
            else if (depth_q == DW'(DEPTH)) err_n = ERR_OVER;
            else begin
              wa_en   = 1'b1;
              wa_data = top;
              depth_n = depth_q + DW'(1);
            end
          end
          OP_SWAP: begin
            if (depth_q < DW'(2)) err_n = ERR_UNDER;
            else begin
              wa_en   = 1'b1;
              wa_addr = dm1[AW-1:0];
              wa_data = sec;
              wb_en   = 1'b1;
              wb_data = top;
            end
          end
          OP_DROP: begin
            if (depth_q == '0) err_n = ERR_UNDER;
            else depth_n = dm1;
          end
          OP_PRINT: begin
            if (depth_q == '0) err_n = ERR_UNDER;
            else prn = 1'b1;
          end
          default: err_n = ERR_INVALID;
        endcase
      end
    end
  end

  // Control/status registers; reset discards any pending deferred op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      err_q     <= ERR_NONE;
      depth_q   <= '0;
      op_q      <= '0;
      drop_q    <= 1'b0;
      res_value <= '0;
      res_ready <= 1'b0;
    end else begin
      state_q   <= state_n;
      err_q     <= err_n;
      depth_q   <= depth_n;
      res_ready <= prn;
      if (prn) res_value <= top;
      if (latch) begin
        op_q   <= op;
        drop_q <= push_ovf;
      end
    end
  end

  // Stack storage: two write ports so SWAP completes in one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wa_en) mem[wa_addr] <= wa_data;
      if (wb_en) mem[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_rpn_core_param.sv
// Directed bench for rpn_core_param (WIDTH=16, DEPTH=8); PRINT results are
// checked through an expected-value queue drained by a strobe monitor.
module tb_rpn_core_param;

  localparam int W = 16;
  localparam int D = 8;
  localparam int DWT = $clog2(D + 1);

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3,
    MOD = 4'd4, NEG = 4'd5, DROP = 4'd8, PRINT = 4'd9, CLEAR = 4'd10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           num_en = 1'b0;
  logic [W-1:0]   num = '0;
  logic           op_en = 1'b0;
  logic [3:0]     op = '0;
  logic           busy;
  logic [W-1:0]   res_value;
  logic           res_ready;
  logic [2:0]     err;
  logic [DWT-1:0] depth;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb [$];

  rpn_core_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .num_en(num_en), .num(num), .op_en(op_en),
    .op(op), .busy(busy), .res_value(res_value), .res_ready(res_ready),
    .err(err), .depth(depth)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus, driven and released on falling edges.
  task automatic step(input logic ne, input logic [W-1:0] n, input logic oe, input logic [3:0] o);
    num_en = ne; num = n; op_en = oe; op = o;
    @(negedge clk);
    num_en = 1'b0; op_en = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] n);
    step(1'b1, n, 1'b0, 4'd0);
  endtask

  task automatic exec(input logic [3:0] o);
    step(1'b0, '0, 1'b1, o);
  endtask

  // Strobe monitor: every res_ready cycle must consume one expected value.
  initial begin
    forever begin
      @(negedge clk);
      if (res_ready) begin
        if (sb.size() == 0) chk("unexpected_res_ready", 32'(res_value), 32'hDEAD);
        else chk("print_value", 32'(res_value), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_ready", 32'(res_ready), 0);
    chk("rst_res_value", 32'(res_value), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_depth", 32'(depth), 0);

    // add / print
    push(16'd3); push(16'd4); exec(ADD);
    sb.push_back(16'h0007); exec(PRINT);
    chk("add_depth", 32'(depth), 1);
    repeat (2) @(negedge clk);
    chk("res_hold", 32'(res_value), 32'h0007);

    // subtract / negate wrap
    exec(CLEAR);
    push(16'd5); push(16'd7); exec(SUB);
    sb.push_back(16'hFFFE); exec(PRINT);
    exec(NEG);
    sb.push_back(16'h0002); exec(PRINT);
    chk("neg_depth", 32'(depth), 1);

    // overflow and recovery
    exec(CLEAR);
    for (int i = 0; i < D; i++) push(16'(i + 10));
    chk("full_err", 32'(err), 0);
    chk("full_depth", 32'(depth), D);
    push(16'd99);
    chk("ovf_err", 32'(err), 2);
    chk("ovf_depth", 32'(depth), D);
    push(16'd98);
    exec(PRINT);
    chk("ovf_ignored_depth", 32'(depth), D);
    exec(CLEAR);
    chk("clr_err", 32'(err), 0);
    chk("clr_depth", 32'(depth), 0);
    push(16'd1);
    chk("recover_depth", 32'(depth), 1);
    sb.push_back(16'h0001); exec(PRINT);

    // underflow and invalid
    exec(CLEAR);
    push(16'd1); exec(ADD);
    chk("uf_err", 32'(err), 1);
    chk("uf_depth", 32'(depth), 1);
    exec(CLEAR);
    exec(PRINT);
    chk("print_empty_err", 32'(err), 1);
    exec(CLEAR);
    exec(4'd12);
    chk("invalid_err", 32'(err), 4);
    chk("invalid_depth", 32'(depth), 0);

    // divide
    exec(CLEAR);
    push(16'hFFF9); push(16'd2); exec(DIV);
`ifdef RPN_DIVIDE_EN
    sb.push_back(16'hFFFD); exec(PRINT);
    chk("div_depth", 32'(depth), 1);
    exec(CLEAR);
    push(16'hFFF9); push(16'd2); exec(MOD);
    sb.push_back(16'hFFFF); exec(PRINT);
    exec(CLEAR);
    push(16'd7); push(16'd0); exec(DIV);
    chk("divz_err", 32'(err), 3);
    chk("divz_depth", 32'(depth), 2);
`else
    chk("div_off_err", 32'(err), 4);
    chk("div_off_depth", 32'(depth), 2);
    exec(CLEAR);
    push(16'd7); push(16'd2); exec(MOD);
    chk("mod_off_err", 32'(err), 4);
`endif

    // deferred op, with a stray pulse while busy
    exec(CLEAR);
    push(16'd3);
    step(1'b1, 16'd2, 1'b1, MUL);
    chk("defer_busy", 32'(busy), 1);
    push(16'd9);
    chk("defer_done_busy", 32'(busy), 0);
    chk("defer_depth", 32'(depth), 1);
    sb.push_back(16'h0006); exec(PRINT);

    // deferred op overflow drops the latched op
    exec(CLEAR);
    for (int i = 0; i < D; i++) push(16'(i));
    step(1'b1, 16'd5, 1'b1, DROP);
    @(negedge clk);
    chk("defer_ovf_err", 32'(err), 2);
    chk("defer_ovf_depth", 32'(depth), D);

    // reset during DEFER
    exec(CLEAR);
    push(16'd3);
    step(1'b1, 16'd2, 1'b1, PRINT);
    chk("defer2_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstdefer_depth", 32'(depth), 0);
    chk("rstdefer_busy", 32'(busy), 0);
    chk("rstdefer_err", 32'(err), 0);
    chk("rstdefer_res_ready", 32'(res_ready), 0);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rpn_core_param.md
Name: rpn_core_param

Overview:
- Parametrised successor to the fixed 16-bit RPN engine.
- Generic WIDTH and DEPTH, registered internal operand stack, extended opcode set, sticky error reporting, and a busy handshake.
- Sits between the UART token parser (num/op pulses) and the UART result formatter (res_value/res_ready).
- Replaces the separate alu / op_controller / stack_controller / stack arrangement with one self-contained sequential block.

Parameters:
- WIDTH, 16: operand/result width, two's complement.
- DEPTH, 8: stack entries, minimum 2.
- DW, $clog2(DEPTH+1): width of the depth output (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- num_en  input  1  one-cycle pulse: push num.
- num  input  WIDTH  operand value.
- op_en  input  1  one-cycle pulse: execute op.
- op  input  4  opcode.
- busy  output  1  high while a deferred op is pending; pulses are ignored while high.
- res_value  output  WIDTH  printed value.
- res_ready  output  1  one-cycle strobe, res_value valid.
- err  output  3  sticky error code.
- depth  output  DW  current stack occupancy.

Behaviour:
- Reset: synchronous, active-high. At rst=1 on a clk edge, all outputs and state go to 0: busy=0, res_value=0, res_ready=0, err=0, depth=0, FSM=IDLE. Stack RAM contents are don't-care. Reset has priority over everything, including a pending deferred op, which is discarded.
- Inputs are sampled at a rising edge when busy=0. The result is visible after that edge (1-cycle latency).
- Operands: a = second-from-top, b = top.
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 MUL: low WIDTH bits of a*b.
  - 3 DIV: a/b, signed, truncating toward zero.
  - 4 MOD: a%b, sign follows a.
  - 5 NEG: -b.
  - 6 DUP.
  - 7 SWAP.
  - 8 DROP.
  - 9 PRINT: peek top, stack unchanged.
  - 10 CLEAR: depth=0, err=0.
  - 11-15: INVALID.
- Arithmetic wraps modulo 2^WIDTH. No overflow flag is raised for arithmetic.
- Binary ops pop 2 and push 1 (depth-1). NEG replaces the top. DUP gives depth+1. SWAP exchanges a and b. DROP gives depth-1.
- err codes:
  - 0 NONE
  - 1 UNDERFLOW: too few operands; PRINT or DROP on empty; binary op or SWAP with depth<2.
  - 2 OVERFLOW: push or DUP at depth==DEPTH.
  - 3 DIVZERO: DIV/MOD with b==0.
  - 4 INVALID: opcode not implemented.
- On any error condition, the stack and depth are left unchanged and err latches the code.
- While err!=0, every num_en and every op other than CLEAR is ignored. CLEAR always executes, even with err set.
- PRINT: the edge after the sample loads res_value=top and sets res_ready=1 for exactly one cycle. res_value holds until the next PRINT. On error, res_ready stays 0.
- FSM states: IDLE, DEFER.
  - IDLE, only num_en: push; stay IDLE.
  - IDLE, only op_en: execute; stay IDLE.
  - IDLE, num_en and op_en together: push num, latch op, go to DEFER, busy=1.
  - DEFER: execute latched op (error rules apply; if the push overflowed, the latched op is dropped); go to IDLE, busy=0.
- Pulses arriving while busy=1 are discarded, not queued.
- depth never exceeds DEPTH and never wraps below 0.

Optional Feature:
- Macro: RPN_DIVIDE_EN.
- Defined: DIV and MOD are implemented as above, including the DIVZERO check.
- Undefined: no divider logic is synthesised. Opcodes 3 and 4 behave as INVALID (err=4, stack unchanged).

Test Plan (WIDTH=16, DEPTH=8):
- Basic add/print: push 3, push 4, ADD, PRINT -> res_value=0x0007, res_ready high exactly 1 cycle, depth=1.
- Subtract/negate wrap: push 5, push 7, SUB, PRINT -> 0xFFFE; then NEG, PRINT -> 0x0002.
- Overflow and recovery: 9 pushes -> err=2 and depth=8 after the 9th; a further push is ignored; CLEAR -> err=0, depth=0; push 1 accepted, depth=1.
- Underflow and invalid: push 1, ADD -> err=1, depth=1, top still 1; CLEAR; op 12 -> err=4.
- Divide (macro on): push 0xFFF9 (-7), push 2, DIV, PRINT -> 0xFFFD; push 7, push 0, DIV -> err=3, depth=2. Macro off: the same DIV sequence -> err=4.
- Deferred op and reset:
  - Stack [3]; num=2 with num_en and op_en(MUL) in the same cycle -> busy=1 for one cycle, then top=6, depth=1.
  - Repeat the same stimulus but assert rst during DEFER -> depth=0, busy=0, err=0, no res_ready.
